// File: rtl/video_timing_pkg.sv
// Video-mode parameter sets and controller state encoding shared by the
// DVI timing generator and its mode controller.
package video_timing_pkg;

    localparam int TABLE_ENTRIES = 4;

    typedef struct packed {
        logic [10:0] h_active;
        logic [10:0] h_fp;
        logic [10:0] h_sync;
        logic [10:0] h_bp;
        logic [10:0] v_active;
        logic [10:0] v_fp;
        logic [10:0] v_sync;
        logic [10:0] v_bp;
        logic        h_pol;
        logic        v_pol;
    } mode_params_t;

    // Field order: h active/fp/sync/bp, v active/fp/sync/bp, h_pol, v_pol (1 = positive)
    localparam mode_params_t MODE_TABLE [TABLE_ENTRIES] = '{
        '{11'd640,  11'd16,  11'd96,  11'd48,  11'd480, 11'd10, 11'd2, 11'd33, 1'b0, 1'b0},
        '{11'd800,  11'd40,  11'd128, 11'd88,  11'd600, 11'd1,  11'd4, 11'd23, 1'b1, 1'b1},
        '{11'd1280, 11'd110, 11'd40,  11'd220, 11'd720, 11'd5,  11'd5, 11'd20, 1'b1, 1'b1},
        '{11'd1024, 11'd24,  11'd136, 11'd160, 11'd768, 11'd3,  11'd6, 11'd29, 1'b0, 1'b0}
    };

    typedef enum logic [1:0] {
        ST_HOLD,
        ST_SYNC,
        ST_RUN,
        ST_DRAIN
    } ctrl_state_t;

endpackage

// File: rtl/frame_end_detect.sv
// Flags the cycle in which data enable falls on the last active line of a frame.
module frame_end_detect
    import video_timing_pkg::*;
(
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_de,
    input  logic [10:0] i_y,
    input  logic [10:0] i_v_active,
    output logic        o_frame_end
);

    logic de_d;
    logic de_q;

    always_comb begin
        de_d = i_de;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            de_q <= 1'b0;
        end else begin
            de_q <= de_d;
        end
    end

    assign o_frame_end = de_q & ~i_de & (i_y == (i_v_active - 11'd1));

endmodule

// File: rtl/timing_mode_controller.sv
// Holds the active video mode for the timing generator and applies mode
// changes at frame boundaries with a reset/settle/startup sequence.
module timing_mode_controller
    import video_timing_pkg::*;
#(
    parameter int NUM_MODES      = 4,
    parameter int SETTLE_CYCLES  = 16,
    parameter int STARTUP_FRAMES = 2
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_req_valid,
    input  logic [1:0]  i_req_mode,
    output logic        o_req_ready,
    output logic        o_req_err,
    input  logic        i_de,
    input  logic [10:0] i_y,
    output logic        o_tg_rst,
    output logic [10:0] o_h_active,
    output logic [10:0] o_h_fp,
    output logic [10:0] o_h_sync,
    output logic [10:0] o_h_bp,
    output logic [10:0] o_v_active,
    output logic [10:0] o_v_fp,
    output logic [10:0] o_v_sync,
    output logic [10:0] o_v_bp,
    output logic        o_h_pol,
    output logic        o_v_pol,
    output logic [1:0]  o_mode,
    output logic        o_locked,
    output logic [15:0] o_frame_count
);

    localparam int              CNT_W        = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [15:0]      STARTUP_DONE = 16'(STARTUP_FRAMES);
    localparam logic [2:0]       MODE_LIMIT   = 3'(NUM_MODES);

    ctrl_state_t      state_d, state_q;
    logic [CNT_W-1:0] settle_cnt_d, settle_cnt_q;
    logic [15:0]      frame_cnt_d, frame_cnt_q;
    logic [1:0]       mode_d, mode_q;
    logic [1:0]       pend_mode_d, pend_mode_q;
    mode_params_t     params_d, params_q;
    logic             req_err_d, req_err_q;
    logic             tg_rst_d, tg_rst_q;
    logic             locked_d, locked_q;
    logic             req_ready_d, req_ready_q;

    logic frame_end;
    logic frame_end_live;
    logic accept;

    frame_end_detect u_frame_end_detect (
        .i_clk      (i_clk),
        .i_rst      (i_rst),
        .i_de       (i_de),
        .i_y        (i_y),
        .i_v_active (params_q.v_active),
        .o_frame_end(frame_end)
    );

    always_comb begin
        state_d      = state_q;
        settle_cnt_d = settle_cnt_q;
        frame_cnt_d  = frame_cnt_q;
        mode_d       = mode_q;
        pend_mode_d  = pend_mode_q;
        params_d     = params_q;
        req_err_d    = 1'b0;

        accept         = i_req_valid & req_ready_q;
        // The generator is held in reset during HOLD, so its timing is meaningless there
        frame_end_live = frame_end & (state_q != ST_HOLD);

        if (frame_end_live) begin
            frame_cnt_d = frame_cnt_q + 16'd1;
        end

        case (state_q)
            ST_HOLD: begin
                if (settle_cnt_q == SETTLE_LAST) begin
                    state_d = ST_SYNC;
                end else begin
                    settle_cnt_d = settle_cnt_q + CNT_W'(1);
                end
            end
            ST_SYNC: begin
                if (frame_end_live && (frame_cnt_d == STARTUP_DONE)) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                if (accept) begin
                    if ({1'b0, i_req_mode} >= MODE_LIMIT) begin
                        req_err_d = 1'b1;
                    end else if (i_req_mode != mode_q) begin
                        pend_mode_d = i_req_mode;
                        state_d     = ST_DRAIN;
                    end
                end
            end
            ST_DRAIN: begin
                // Swap parameters and restart the generator in the same edge
                if (frame_end_live) begin
                    params_d     = MODE_TABLE[pend_mode_q];
                    mode_d       = pend_mode_q;
                    state_d      = ST_HOLD;
                    settle_cnt_d = '0;
                    frame_cnt_d  = '0;
                end
            end
            default: begin
                state_d = ST_HOLD;
            end
        endcase

        tg_rst_d    = (state_d == ST_HOLD);
        req_ready_d = (state_d == ST_RUN);
        locked_d    = (state_d == ST_RUN) || (state_d == ST_DRAIN);
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q      <= ST_HOLD;
            settle_cnt_q <= '0;
            frame_cnt_q  <= '0;
            mode_q       <= 2'd0;
            pend_mode_q  <= 2'd0;
            params_q     <= MODE_TABLE[0];
            req_err_q    <= 1'b0;
            tg_rst_q     <= 1'b1;
            locked_q     <= 1'b0;
            req_ready_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            settle_cnt_q <= settle_cnt_d;
            frame_cnt_q  <= frame_cnt_d;
            mode_q       <= mode_d;
            pend_mode_q  <= pend_mode_d;
            params_q     <= params_d;
            req_err_q    <= req_err_d;
            tg_rst_q     <= tg_rst_d;
            locked_q     <= locked_d;
            req_ready_q  <= req_ready_d;
        end
    end

    assign o_req_ready   = req_ready_q;
    assign o_req_err     = req_err_q;
    assign o_tg_rst      = tg_rst_q;
    assign o_locked      = locked_q;
    assign o_mode        = mode_q;
    assign o_frame_count = frame_cnt_q;
    assign o_h_active    = params_q.h_active;
    assign o_h_fp        = params_q.h_fp;
    assign o_h_sync      = params_q.h_sync;
    assign o_h_bp        = params_q.h_bp;
    assign o_v_active    = params_q.v_active;
    assign o_v_fp        = params_q.v_fp;
    assign o_v_sync      = params_q.v_sync;
    assign o_v_bp        = params_q.v_bp;
    assign o_h_pol       = params_q.h_pol;
    assign o_v_pol       = params_q.v_pol;

endmodule

// File: tb/tb_timing_mode_controller.sv
// Scoreboard bench for timing_mode_controller driven by a line-compressed
// behavioural timing generator (two cycles per line, real line counts).
module tb_timing_mode_controller;

    localparam int NUM_MODES  = 3;
    localparam int SETTLE     = 16;
    localparam int STARTUP    = 2;
    localparam int REQ_BUDGET = 6000;
    localparam int RUN_BUDGET = 6000;

    localparam int H_ACT [4] = '{640, 800, 1280, 1024};
    localparam int H_FP  [4] = '{16, 40, 110, 24};
    localparam int H_SY  [4] = '{96, 128, 40, 136};
    localparam int H_BP  [4] = '{48, 88, 220, 160};
    localparam int V_ACT [4] = '{480, 600, 720, 768};
    localparam int V_FP  [4] = '{10, 1, 5, 3};
    localparam int V_SY  [4] = '{2, 4, 5, 6};
    localparam int V_BP  [4] = '{33, 23, 20, 29};
    localparam int POL   [4] = '{0, 1, 1, 0};

    localparam int P_HOLD  = 0;
    localparam int P_SYNC  = 1;
    localparam int P_RUN   = 2;
    localparam int P_DRAIN = 3;

    typedef struct packed {
        logic        tg_rst;
        logic        ready;
        logic        err;
        logic        locked;
        logic [1:0]  mode;
        logic [15:0] fcnt;
    } snap_t;

    logic        clk = 1'b0;
    logic        i_rst = 1'b1;
    logic        i_req_valid = 1'b0;
    logic [1:0]  i_req_mode = 2'd0;
    logic        i_de = 1'b0;
    logic [10:0] i_y = 11'd0;
    logic        o_req_ready, o_req_err, o_tg_rst, o_locked;
    logic [10:0] o_h_active, o_h_fp, o_h_sync, o_h_bp;
    logic [10:0] o_v_active, o_v_fp, o_v_sync, o_v_bp;
    logic        o_h_pol, o_v_pol;
    logic [1:0]  o_mode;
    logic [15:0] o_frame_count;

    int    checks = 0;
    int    errors = 0;
    snap_t exp_q [$];

    timing_mode_controller #(
        .NUM_MODES     (NUM_MODES),
        .SETTLE_CYCLES (SETTLE),
        .STARTUP_FRAMES(STARTUP)
    ) dut (
        .i_clk        (clk),
        .i_rst        (i_rst),
        .i_req_valid  (i_req_valid),
        .i_req_mode   (i_req_mode),
        .o_req_ready  (o_req_ready),
        .o_req_err    (o_req_err),
        .i_de         (i_de),
        .i_y          (i_y),
        .o_tg_rst     (o_tg_rst),
        .o_h_active   (o_h_active),
        .o_h_fp       (o_h_fp),
        .o_h_sync     (o_h_sync),
        .o_h_bp       (o_h_bp),
        .o_v_active   (o_v_active),
        .o_v_fp       (o_v_fp),
        .o_v_sync     (o_v_sync),
        .o_v_bp       (o_v_bp),
        .o_h_pol      (o_h_pol),
        .o_v_pol      (o_v_pol),
        .o_mode       (o_mode),
        .o_locked     (o_locked),
        .o_frame_count(o_frame_count)
    );

    always #5 clk = ~clk;

    function automatic logic [89:0] exp_params(input int m);
        return {11'(H_ACT[m]), 11'(H_FP[m]), 11'(H_SY[m]), 11'(H_BP[m]),
                11'(V_ACT[m]), 11'(V_FP[m]), 11'(V_SY[m]), 11'(V_BP[m]),
                1'(POL[m]), 1'(POL[m])};
    endfunction

    // Generator: each line is one DE cycle then one blank cycle; blanking lines have no DE
    initial begin
        int gh, gy, va, vt;
        gh = 0;
        gy = 0;
        forever begin
            @(posedge clk);
            #1;
            if (o_tg_rst !== 1'b0) begin
                gh   = 0;
                gy   = 0;
                i_de = 1'b0;
                i_y  = 11'd0;
            end else begin
                va   = int'(o_v_active);
                vt   = va + int'(o_v_fp) + int'(o_v_sync) + int'(o_v_bp);
                i_y  = 11'(gy);
                i_de = (gh == 0) && (gy < va);
                gh++;
                if (gh == 2) begin
                    gh = 0;
                    gy++;
                    if (gy >= vt) gy = 0;
                end
            end
        end
    end

    // Reference model: predicts the outputs after each edge from the inputs of the cycle before it
    initial begin
        int    m_phase, m_hold, m_frames, m_mode, m_pend;
        bit    m_err, m_de_prev, fe;
        snap_t s;
        m_phase = P_HOLD; m_hold = 0; m_frames = 0; m_mode = 0; m_pend = 0;
        m_err = 1'b0; m_de_prev = 1'b0;
        forever begin
            @(negedge clk);
            fe        = m_de_prev && !i_de && (int'(i_y) == V_ACT[m_mode] - 1);
            m_de_prev = i_de;
            if (i_rst) begin
                m_phase = P_HOLD; m_hold = 0; m_frames = 0; m_mode = 0; m_err = 1'b0;
            end else begin
                m_err = 1'b0;
                if (fe && m_phase != P_HOLD) m_frames = (m_frames + 1) % 65536;
                case (m_phase)
                    P_HOLD: begin
                        m_hold++;
                        if (m_hold == SETTLE) m_phase = P_SYNC;
                    end
                    P_SYNC: if (fe && m_frames == STARTUP) m_phase = P_RUN;
                    P_RUN: begin
                        if (i_req_valid) begin
                            if (int'(i_req_mode) >= NUM_MODES) m_err = 1'b1;
                            else if (int'(i_req_mode) != m_mode) begin
                                m_pend  = int'(i_req_mode);
                                m_phase = P_DRAIN;
                            end
                        end
                    end
                    default: begin
                        if (fe) begin
                            m_mode = m_pend; m_phase = P_HOLD; m_hold = 0; m_frames = 0;
                        end
                    end
                endcase
            end
            s.tg_rst = (m_phase == P_HOLD);
            s.ready  = (m_phase == P_RUN);
            s.err    = m_err;
            s.locked = (m_phase == P_RUN) || (m_phase == P_DRAIN);
            s.mode   = 2'(m_mode);
            s.fcnt   = 16'(m_frames);
            exp_q.push_back(s);
        end
    end

    // Monitor: compares every registered output state against the oldest prediction
    initial begin
        snap_t       e, a;
        logic [89:0] pa, pe;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                a = {o_tg_rst, o_req_ready, o_req_err, o_locked, o_mode, o_frame_count};
                checks++;
                if (a !== e) begin
                    errors++;
                    $display("FAIL status @%0t: got tg_rst=%b ready=%b err=%b locked=%b mode=%0d fcnt=%0d, expected tg_rst=%b ready=%b err=%b locked=%b mode=%0d fcnt=%0d",
                             $time, a.tg_rst, a.ready, a.err, a.locked, a.mode, a.fcnt,
                             e.tg_rst, e.ready, e.err, e.locked, e.mode, e.fcnt);
                end
                pa = {o_h_active, o_h_fp, o_h_sync, o_h_bp, o_v_active, o_v_fp,
                      o_v_sync, o_v_bp, o_h_pol, o_v_pol};
                pe = exp_params(int'(e.mode));
                checks++;
                if (pa !== pe) begin
                    errors++;
                    $display("FAIL params @%0t: got %h, expected %h (mode %0d)", $time, pa, pe, e.mode);
                end
            end
        end
    end

    task automatic send_req(input logic [1:0] m);
        bit acc;
        int n;
        acc = 1'b0;
        n = 0;
        i_req_valid = 1'b1;
        i_req_mode  = m;
        while (!acc && n < REQ_BUDGET) begin
            @(negedge clk);
            acc = (o_req_ready === 1'b1);
            @(posedge clk);
            #1;
            n++;
        end
        i_req_valid = 1'b0;
        checks++;
        if (!acc) begin
            errors++;
            $display("FAIL req_accept: mode %0d not accepted in %0d cycles, required acceptance", m, REQ_BUDGET);
        end
    endtask

    task automatic wait_run();
        bit ok;
        int n;
        ok = 1'b0;
        n = 0;
        while (!ok && n < RUN_BUDGET) begin
            @(negedge clk);
            ok = (o_req_ready === 1'b1) && (o_locked === 1'b1);
            n++;
        end
        @(posedge clk);
        #1;
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL wait_run: ready=%b locked=%b after %0d cycles, required both 1", o_req_ready, o_locked, RUN_BUDGET);
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        #(95000 * 10);
        $display("FAIL watchdog: simulation exceeded cycle limit");
        $fatal(1, "watchdog");
    end

    initial begin
        cycles(5);
        i_rst = 1'b0;
        wait_run();

        // Same-mode and out-of-range requests must leave the lock untouched
        send_req(2'd0);
        cycles(20);
        send_req(2'd3);
        cycles(20);

        cycles(300);
        send_req(2'd2);
        wait_run();

        // Second request held valid through DRAIN until RUN returns
        send_req(2'd0);
        send_req(2'd1);
        wait_run();

        send_req(2'd2);
        cycles(5);
        i_rst = 1'b1;
        cycles(2);
        i_rst = 1'b0;
        wait_run();

        for (int k = 0; k < 8; k++) begin
            cycles(int'($urandom_range(0, 900)));
            send_req(2'($urandom_range(0, 3)));
        end
        wait_run();
        cycles(4);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/timing_mode_controller.md
# timing_mode_controller

Sequencer and configurator for the DVI `timing_generator`. It holds the active video-mode parameter set and accepts mode-change requests over a valid/ready handshake. Each change is applied only at a frame boundary: the controller holds the generator in reset for a settle period, then waits for a startup period before reporting lock. It sits between the control/CPU side and the timing generator, and feeds the generator's timing inputs and reset.

## Interface
- `NUM_MODES`, 4: valid mode table entries, at most 4.
- `SETTLE_CYCLES`, 16: cycles `o_tg_rst` is held high per (re)start, minimum 1.
- `STARTUP_FRAMES`, 2: frame ends required after a (re)start before `o_locked` rises, minimum 1.

Ports (clock and reset first):
- `i_clk`  in  1  pixel clock.
- `i_rst`  in  1  synchronous, active-high reset.
- `i_req_valid`  in  1  mode-change request valid.
- `i_req_mode`  in  2  requested mode index.
- `o_req_ready`  out  1  request accepted when `i_req_valid & o_req_ready`.
- `o_req_err`  out  1  one-cycle pulse when an accepted index is `>= NUM_MODES`.
- `i_de`, `i_y`  in  1, 11  data enable and line counter from the generator.
- `o_tg_rst`  out  1  active-high generator reset; the top level inverts it onto the generator's `i_rstn`.
- `o_h_active`, `o_h_fp`, `o_h_sync`, `o_h_bp`  out  11 each  horizontal timing.
- `o_v_active`, `o_v_fp`, `o_v_sync`, `o_v_bp`  out  11 each  vertical timing.
- `o_h_pol`, `o_v_pol`  out  1 each  sync polarity, 1 = positive.
- `o_mode`  out  2  index of the mode currently driven on the parameter outputs.
- `o_locked`  out  1  generator running stably in `o_mode`.
- `o_frame_count`  out  16  frame ends since the last (re)start.

## Operation
- States:
  - HOLD: `o_tg_rst`=1, settle counter running.
  - SYNC: generator running, counting startup frames.
  - RUN: `o_req_ready`=1, `o_locked`=1.
  - DRAIN: change pending, waiting for frame end.
- Frame end: `de_q & ~i_de & (i_y == o_v_active-1)`, where `de_q` is `i_de` registered once. It is ignored in HOLD.
- HOLD → SYNC when the settle counter reaches `SETTLE_CYCLES-1`. The counter and `o_frame_count` clear on HOLD entry.
- SYNC → RUN on the frame end that brings `o_frame_count` to `STARTUP_FRAMES`.
- RUN, accept with an index `>= NUM_MODES`: pulse `o_req_err`, stay in RUN, no parameter change.
- RUN, accept with index == `o_mode`: no-op, stay in RUN, lock held.
- RUN, accept with any other valid index: latch it as the pending mode and go to DRAIN.
- DRAIN: `o_req_ready`=0 and `o_locked` stays 1. On frame end, load all parameter outputs and `o_mode` from the pending entry, then go to HOLD with `o_tg_rst`=1 and `o_locked`=0.
- `o_frame_count` increments on every frame end in SYNC, RUN and DRAIN, and wraps at 16 bits.
- `i_rst` in any state: return to HOLD with mode 0 and drop any pending request.

## Timing
- Reset values:
  - `o_tg_rst`=1, `o_req_ready`=0, `o_req_err`=0, `o_locked`=0, `o_frame_count`=0, `o_mode`=0.
  - Parameters = mode 0 (640x480).
- All outputs are registered.
- `o_tg_rst` is high for exactly `SETTLE_CYCLES` cycles after the cycle in which `i_rst` is sampled low.
- Accept in cycle N: `o_req_ready`=0 from N+1.
- Frame end detected in cycle F: parameters, `o_mode`, `o_tg_rst`=1 and `o_locked`=0 all change at the edge ending F, together.
- `o_locked` rises at the edge ending the `STARTUP_FRAMES`-th frame-end cycle. `o_req_ready` rises with it.
- `o_req_err` is asserted in cycle N+1 for an invalid accept in N.

## Structure
- Package `video_timing_pkg` holds:
  - A `mode_params_t` struct with eight 11-bit fields and two polarity bits.
  - A `MODE_TABLE` constant with these entries (active/fp/sync/bp, polarity):

    | Mode | Resolution | Horizontal | Vertical | Polarity |
    |---|---|---|---|---|
    | 0 | 640x480 | 640/16/96/48 | 480/10/2/33 | −/− |
    | 1 | 800x600 | 800/40/128/88 | 600/1/4/23 | +/+ |
    | 2 | 1280x720 | 1280/110/40/220 | 720/5/5/20 | +/+ |
    | 3 | 1024x768 | 1024/24/136/160 | 768/3/6/29 | −/− |

  - The state enum.
- Natural sub-module: `frame_end_detect`, which registers `i_de`, compares `i_y`, and outputs a one-cycle pulse.

## Test plan
The bench drives `i_de` and `i_y` from a behavioural generator model that consumes the parameter outputs.
- Reset, then idle → `o_tg_rst` high 16 cycles; `o_locked` rises after 2 frames of 800x525 = 840000 cycles; `o_mode`=0.
- While locked, request mode 2 mid-frame → `o_req_ready` drops next cycle; parameters still 640 until frame end. At frame end: 1280/720 loaded, `o_tg_rst` high 16 cycles, lock after 2 frames of 1650x750.
- Request mode 0 while in mode 0 → accepted, `o_locked` never drops, no `o_tg_rst` pulse.
- Request index 3 with `NUM_MODES`=3 → single-cycle `o_req_err`, mode unchanged.
- Hold `i_req_valid` high during DRAIN with a different index → not accepted until RUN returns; then accepted on the first ready cycle.
- Assert `i_rst` in DRAIN → pending change dropped; mode 0, HOLD, `o_frame_count`=0.
